// File: rtl/dkong_vram_cpu_if_if.sv
// dkong_vram_cpu_if_if: CPU bus and VRAM bus signals of the VRAM CPU initiator.
// master = the initiator itself, slave = the environment (CPU decode + renderer).
interface dkong_vram_cpu_if_if;
  logic        CLK_EN;
  logic [15:0] I_CPU_A;
  logic [7:0]  I_CPU_D;
  logic        I_CPU_MREQn;
  logic        I_CPU_RDn;
  logic        I_CPU_WRn;
  logic [7:0]  O_CPU_D;
  logic        O_CPU_WAITn;
  logic [9:0]  O_VRAM_AB;
  logic [7:0]  O_VRAM_DB;
  logic        O_VRAM_WRn;
  logic        O_VRAM_RDn;
  logic [7:0]  I_VRAM_DB;
  logic        I_VRAMBUSYn;
  logic        O_TIMEOUT;

  modport master (
    input  CLK_EN, I_CPU_A, I_CPU_D, I_CPU_MREQn, I_CPU_RDn, I_CPU_WRn,
           I_VRAM_DB, I_VRAMBUSYn,
    output O_CPU_D, O_CPU_WAITn, O_VRAM_AB, O_VRAM_DB, O_VRAM_WRn, O_VRAM_RDn,
           O_TIMEOUT
  );

  modport slave (
    output CLK_EN, I_CPU_A, I_CPU_D, I_CPU_MREQn, I_CPU_RDn, I_CPU_WRn,
           I_VRAM_DB, I_VRAMBUSYn,
    input  O_CPU_D, O_CPU_WAITn, O_VRAM_AB, O_VRAM_DB, O_VRAM_WRn, O_VRAM_RDn,
           O_TIMEOUT
  );
endinterface

// File: rtl/dkong_vram_cpu_if.sv
// dkong_vram_cpu_if: decodes Z80 cycles in the VRAM window, stalls the CPU via
// WAITn until the renderer grants the bus, then runs one registered VRAM strobe.
// Optional build macro VRAM_POSTED_WR_EN adds a one-entry posted write buffer.
//
// state  | meaning
// IDLE   | no access in flight; sample CPU requests on ticks
// ARB    | access latched, waiting for VRAMBUSYn (or the wait limit)
// STROBE | VRAM strobe held low for STROBE_LEN ticks
// DONE   | access finished, read data returned until the CPU ends its cycle
module dkong_vram_cpu_if #(
  parameter logic [5:0] BASE_ADDR  = 6'h1D,
  parameter int         STROBE_LEN = 2,
  parameter int         MAX_WAIT   = 1023
) (
  input logic                 CLK_24M,
  input logic                 I_RST,
  dkong_vram_cpu_if_if.master bus
);
  typedef enum logic [1:0] {IDLE, ARB, STROBE, DONE} state_t;

  localparam logic [2:0] STR_LOAD = 3'(STROBE_LEN);
  localparam logic [9:0] WAIT_LIM = 10'(MAX_WAIT);

  state_t     state, state_nx;
  logic       tick, req, req_new, grant, str_last, is_post;
  logic       dir_wr, wait_n, wr_n, rd_n, timeout, abort_seen;
  logic [9:0] addr, wait_cnt;
  logic [7:0] wdata, rd_latch, cpu_d;
  logic [2:0] str_cnt;

  assign tick     = bus.CLK_EN;
  assign req      = !bus.I_CPU_MREQn && (!bus.I_CPU_RDn || !bus.I_CPU_WRn) &&
                    (bus.I_CPU_A[15:10] == BASE_ADDR);
  assign grant    = bus.I_VRAMBUSYn || (wait_cnt == WAIT_LIM);
  assign str_last = (str_cnt == 3'd1);

`ifdef VRAM_POSTED_WR_EN
  // cyc_open stops a CPU cycle that was already accepted from being seen as
  // a second request while its posted write drains.
  logic posted, cyc_open;
  assign req_new = req && !cyc_open;
  assign is_post = posted;
`else
  assign req_new = req;
  assign is_post = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK_24M or posedge I_RST) begin
    if (I_RST) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode; nothing moves without a tick
  always_comb begin
    state_nx = state;
    if (tick) begin
      case (state)
        IDLE:    if (req_new) state_nx = ARB;
        ARB:     if (grant) state_nx = STROBE;
        STROBE:  if (str_last)
                   state_nx = (is_post || abort_seen || bus.I_CPU_MREQn) ? IDLE : DONE;
        DONE:    if (bus.I_CPU_MREQn) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // access latches, counters, registered strobes and WAITn
  always_ff @(posedge CLK_24M or posedge I_RST) begin
    if (I_RST) begin
      dir_wr     <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rd_latch   <= '0;
      wait_n     <= 1'b1;
      wr_n       <= 1'b1;
      rd_n       <= 1'b1;
      timeout    <= 1'b0;
      abort_seen <= 1'b0;
      wait_cnt   <= '0;
      str_cnt    <= '0;
`ifdef VRAM_POSTED_WR_EN
      posted     <= 1'b0;
      cyc_open   <= 1'b0;
`endif
    end else if (tick) begin
`ifdef VRAM_POSTED_WR_EN
      if (bus.I_CPU_MREQn) cyc_open <= 1'b0;
`endif
      case (state)
        IDLE: if (req_new) begin
          addr       <= bus.I_CPU_A[9:0];
          wdata      <= bus.I_CPU_D;
          dir_wr     <= !bus.I_CPU_WRn;
          wait_cnt   <= '0;
          abort_seen <= 1'b0;
`ifdef VRAM_POSTED_WR_EN
          posted     <= !bus.I_CPU_WRn;
          cyc_open   <= 1'b1;
          wait_n     <= !bus.I_CPU_WRn;
`else
          wait_n     <= 1'b0;
`endif
        end
        ARB: begin
          if (bus.I_CPU_MREQn) abort_seen <= 1'b1;
          if (grant) begin
            wr_n    <= !dir_wr;
            rd_n    <= dir_wr;
            str_cnt <= STR_LOAD;
            if (!bus.I_VRAMBUSYn) timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        STROBE: begin
          if (bus.I_CPU_MREQn) abort_seen <= 1'b1;
          str_cnt <= str_cnt - 3'd1;
          if (str_last) begin
            wr_n <= 1'b1;
            rd_n <= 1'b1;
            if (!dir_wr) rd_latch <= bus.I_VRAM_DB;
            if (!is_post) wait_n <= 1'b1;
          end
        end
        default: ;
      endcase
`ifdef VRAM_POSTED_WR_EN
      // a new request while the buffer drains is held off until it is empty
      if (posted && req_new && (state == ARB || state == STROBE)) wait_n <= 1'b0;
`endif
    end
  end

  // read data onto the CPU OR-bus only while the CPU is reading it back
  always_comb begin
    cpu_d = 8'h00;
    if (state == DONE && !dir_wr && !bus.I_CPU_RDn) cpu_d = rd_latch;
  end

  assign bus.O_CPU_D     = cpu_d;
  assign bus.O_CPU_WAITn = wait_n;
  assign bus.O_VRAM_AB   = addr;
  assign bus.O_VRAM_DB   = wdata;
  assign bus.O_VRAM_WRn  = wr_n;
  assign bus.O_VRAM_RDn  = rd_n;
  assign bus.O_TIMEOUT   = timeout;
endmodule

// File: tb/tb_dkong_vram_cpu_if.sv
// tb_dkong_vram_cpu_if: directed bench for the VRAM CPU initiator. u_dut uses
// the default parameters, u_dut_to a short wait limit for the timeout case;
// both see the same stimulus.
module tb_dkong_vram_cpu_if;
  logic CLK_24M;
  logic I_RST;

  dkong_vram_cpu_if_if bus_a ();
  dkong_vram_cpu_if_if bus_t ();

  assign bus_t.CLK_EN      = bus_a.CLK_EN;
  assign bus_t.I_CPU_A     = bus_a.I_CPU_A;
  assign bus_t.I_CPU_D     = bus_a.I_CPU_D;
  assign bus_t.I_CPU_MREQn = bus_a.I_CPU_MREQn;
  assign bus_t.I_CPU_RDn   = bus_a.I_CPU_RDn;
  assign bus_t.I_CPU_WRn   = bus_a.I_CPU_WRn;
  assign bus_t.I_VRAM_DB   = bus_a.I_VRAM_DB;
  assign bus_t.I_VRAMBUSYn = bus_a.I_VRAMBUSYn;

  dkong_vram_cpu_if u_dut (.CLK_24M(CLK_24M), .I_RST(I_RST), .bus(bus_a));
  dkong_vram_cpu_if #(.MAX_WAIT(4)) u_dut_to (.CLK_24M(CLK_24M), .I_RST(I_RST), .bus(bus_t));

  int n_err = 0;
  int n_chk = 0;

  int         m_wait, m_str, m_first;
  bit         m_both, m_wrong, m_dnz, m_to;
  logic [9:0] m_ab;
  logic [7:0] m_db;

  initial begin
    CLK_24M = 1'b0;
    forever #5 CLK_24M = ~CLK_24M;
  end

  // tick on every second clock so non-tick edges are exercised too
  initial begin
    bus_a.CLK_EN = 1'b0;
    forever begin
      @(negedge CLK_24M);
      bus_a.CLK_EN = ~bus_a.CLK_EN;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge CLK_24M); while (bus_a.CLK_EN !== 1'b1);
    #1;
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [7:0] d, input bit wr);
    bus_a.I_CPU_A     = a;
    bus_a.I_CPU_D     = d;
    bus_a.I_CPU_MREQn = 1'b0;
    bus_a.I_CPU_WRn   = !wr;
    bus_a.I_CPU_RDn   = wr;
  endtask

  task automatic drop_req();
    bus_a.I_CPU_MREQn = 1'b1;
    bus_a.I_CPU_RDn   = 1'b1;
    bus_a.I_CPU_WRn   = 1'b1;
  endtask

  // Runs ticks from the request tick (t=1) until WAITn has gone low and come
  // back high, recording WAITn/strobe lengths and the bus seen under the strobe.
  task automatic measure(input bit use_t, input bit wr, input int busy_lo, input int budget);
    logic w, rd, wrs, s, o;
    logic [7:0] d;
    bit seen;
    m_wait = 0; m_str = 0; m_first = 0;
    m_both = 0; m_wrong = 0; m_dnz = 0; m_to = 1; seen = 0;
    bus_a.I_VRAMBUSYn = (busy_lo == 0);
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (t == busy_lo + 1) bus_a.I_VRAMBUSYn = 1'b1;
      w   = use_t ? bus_t.O_CPU_WAITn : bus_a.O_CPU_WAITn;
      rd  = use_t ? bus_t.O_VRAM_RDn  : bus_a.O_VRAM_RDn;
      wrs = use_t ? bus_t.O_VRAM_WRn  : bus_a.O_VRAM_WRn;
      d   = use_t ? bus_t.O_CPU_D     : bus_a.O_CPU_D;
      s   = wr ? wrs : rd;
      o   = wr ? rd : wrs;
      if (!rd && !wrs) m_both = 1;
      if (!o) m_wrong = 1;
      if (!s) begin
        m_str++;
        if (m_first == 0) m_first = t;
        m_ab = use_t ? bus_t.O_VRAM_AB : bus_a.O_VRAM_AB;
        m_db = use_t ? bus_t.O_VRAM_DB : bus_a.O_VRAM_DB;
      end
      if (!w) begin
        m_wait++;
        seen = 1;
        if (d != 8'h00) m_dnz = 1;
      end else if (seen) begin
        m_to = 0;
        break;
      end
    end
    check_val("access_completes", 32'(m_to), 32'd0);
  endtask

  task automatic outside_window(input string tag, input logic [15:0] a, input bit wr);
    bit bad;
    bad = 0;
    drive_req(a, 8'h66, wr);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!bus_a.O_CPU_WAITn || !bus_a.O_VRAM_WRn || !bus_a.O_VRAM_RDn ||
          bus_a.O_CPU_D != 8'h00) bad = 1;
    end
    check_val(tag, 32'(bad), 32'd0);
    drop_req();
    tick();
  endtask

  initial begin
    int cnt;
    I_RST = 1'b1;
    drop_req();
    bus_a.I_CPU_A     = 16'h0000;
    bus_a.I_CPU_D     = 8'h00;
    bus_a.I_VRAM_DB   = 8'h3C;
    bus_a.I_VRAMBUSYn = 1'b1;
    #23;
    check_val("rst_waitn",   32'(bus_a.O_CPU_WAITn), 32'd1);
    check_val("rst_wrn",     32'(bus_a.O_VRAM_WRn),  32'd1);
    check_val("rst_rdn",     32'(bus_a.O_VRAM_RDn),  32'd1);
    check_val("rst_cpu_d",   32'(bus_a.O_CPU_D),     32'h00);
    check_val("rst_ab",      32'(bus_a.O_VRAM_AB),   32'h000);
    check_val("rst_db",      32'(bus_a.O_VRAM_DB),   32'h00);
    check_val("rst_timeout", 32'(bus_a.O_TIMEOUT),   32'd0);
    #4 I_RST = 1'b0;
    tick();

    // write 0x7412 <- 0xA5, renderer idle
    drive_req(16'h7412, 8'hA5, 1'b1);
    @(posedge CLK_24M);
    #1;
    check_val("no_tick_no_change", 32'(bus_a.O_CPU_WAITn), 32'd1);
    measure(1'b0, 1'b1, 0, 20);
    check_val("wr_wait_ticks", 32'(m_wait),  32'd3);
    check_val("wr_strobe_len", 32'(m_str),   32'd2);
    check_val("wr_strobe_at",  32'(m_first), 32'd2);
    check_val("wr_ab",         32'(m_ab),    32'h012);
    check_val("wr_db",         32'(m_db),    32'hA5);
    check_val("wr_rdn_quiet",  32'(m_wrong), 32'd0);
    check_val("wr_one_strobe", 32'(m_both),  32'd0);
    check_val("wr_no_timeout", 32'(bus_t.O_TIMEOUT), 32'd0);
    drop_req();
    tick();
    tick();

    // window edges: one above, one below
    outside_window("outside_7800", 16'h7800, 1'b0);
    outside_window("outside_73ff", 16'h73FF, 1'b1);
    check_val("ab_held", 32'(bus_a.O_VRAM_AB), 32'h012);
    check_val("db_held", 32'(bus_a.O_VRAM_DB), 32'hA5);

    // renderer never releases: short-limit instance forces the access at t0+5
    drive_req(16'h77FF, 8'h5A, 1'b1);
    measure(1'b1, 1'b1, 1000, 20);
    check_val("to_strobe_at",  32'(m_first), 32'd6);
    check_val("to_wait_ticks", 32'(m_wait),  32'd7);
    check_val("to_strobe_len", 32'(m_str),   32'd2);
    check_val("to_ab",         32'(m_ab),    32'h3FF);
    check_val("to_flag",       32'(bus_t.O_TIMEOUT), 32'd1);
    check_val("to_main_clear", 32'(bus_a.O_TIMEOUT), 32'd0);

    // main instance is still in ARB: CPU abandons the cycle, access must finish
    drop_req();
    tick();
    tick();
    bus_a.I_VRAMBUSYn = 1'b1;
    cnt = 0;
    m_to = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus_a.O_VRAM_WRn) cnt++;
      if (bus_a.O_CPU_WAITn) begin
        m_to = 0;
        break;
      end
    end
    check_val("abort_completes",  32'(m_to), 32'd0);
    check_val("abort_strobe_len", 32'(cnt),  32'd2);
    check_val("to_flag_sticky",   32'(bus_t.O_TIMEOUT), 32'd1);
    // no DONE wait after an abort: the next cycle starts straight away
    drive_req(16'h7401, 8'h11, 1'b1);
    measure(1'b0, 1'b1, 0, 20);
    check_val("post_abort_wait", 32'(m_wait), 32'd3);
    check_val("post_abort_ab",   32'(m_ab),   32'h001);
    drop_req();
    tick();
    tick();

    // reset while the write strobe is low
    drive_req(16'h7455, 8'h77, 1'b1);
    tick();
    tick();
    check_val("rst_mid_wrn_low", 32'(bus_a.O_VRAM_WRn), 32'd0);
    #3 I_RST = 1'b1;
    #1;
    check_val("rst_mid_wrn",     32'(bus_a.O_VRAM_WRn),  32'd1);
    check_val("rst_mid_waitn",   32'(bus_a.O_CPU_WAITn), 32'd1);
    check_val("rst_mid_ab",      32'(bus_a.O_VRAM_AB),   32'h000);
    check_val("rst_clr_timeout", 32'(bus_t.O_TIMEOUT),   32'd0);
    drop_req();
    #7 I_RST = 1'b0;
    tick();
    tick();

    // read 0x7400, renderer busy for 5 ticks, VRAM returns 0x3C
    bus_a.I_VRAM_DB = 8'h3C;
    drive_req(16'h7400, 8'h00, 1'b0);
    measure(1'b0, 1'b0, 5, 30);
    check_val("rd_wait_ticks", 32'(m_wait),  32'd8);
    check_val("rd_strobe_len", 32'(m_str),   32'd2);
    check_val("rd_strobe_at",  32'(m_first), 32'd7);
    check_val("rd_ab",         32'(m_ab),    32'h000);
    check_val("rd_wrn_quiet",  32'(m_wrong), 32'd0);
    check_val("rd_d_zero_wait", 32'(m_dnz),  32'd0);
    check_val("rd_cpu_d",      32'(bus_a.O_CPU_D), 32'h3C);
    bus_a.I_VRAM_DB = 8'hFF;
    #1;
    check_val("rd_latched",    32'(bus_a.O_CPU_D), 32'h3C);
    bus_a.I_CPU_RDn = 1'b1;
    #1;
    check_val("rd_d_released", 32'(bus_a.O_CPU_D), 32'h00);
    drop_req();
    tick();
    tick();

`ifdef VRAM_POSTED_WR_EN
    // two back-to-back writes into a busy renderer: first posted, second held
    begin
      logic [9:0] ab_seq [2];
      logic [7:0] db_seq [2];
      int n_wr;
      logic prev_wrn;
      bus_a.I_VRAMBUSYn = 1'b0;
      drive_req(16'h7420, 8'h01, 1'b1);
      tick();
      check_val("pw_first_no_wait", 32'(bus_a.O_CPU_WAITn), 32'd1);
      drop_req();
      tick();
      drive_req(16'h7421, 8'h02, 1'b1);
      tick();
      check_val("pw_second_waits", 32'(bus_a.O_CPU_WAITn), 32'd0);
      bus_a.I_VRAMBUSYn = 1'b1;
      n_wr = 0;
      prev_wrn = 1'b1;
      for (int i = 0; i < 40 && n_wr < 2; i++) begin
        tick();
        if (!bus_a.O_VRAM_WRn && prev_wrn) begin
          ab_seq[n_wr] = bus_a.O_VRAM_AB;
          db_seq[n_wr] = bus_a.O_VRAM_DB;
          n_wr++;
        end
        prev_wrn = bus_a.O_VRAM_WRn;
        if (bus_a.O_CPU_WAITn && !bus_a.I_CPU_MREQn) drop_req();
      end
      check_val("pw_count", 32'(n_wr), 32'd2);
      check_val("pw_ab0", 32'(ab_seq[0]), 32'h020);
      check_val("pw_db0", 32'(db_seq[0]), 32'h01);
      check_val("pw_ab1", 32'(ab_seq[1]), 32'h021);
      check_val("pw_db1", 32'(db_seq[1]), 32'h02);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
